// File: rtl/wdmem_pkg.sv
// Shared definitions for the result write-back memory: fill-state encoding
// and default geometry.
package wdmem_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 1024;

  // Fill level of the write-back memory
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/wdmem_ram.sv
// Inferred simple dual-port RAM: one write port, one registered read-first
// read port. The read port exists only when WDATA_MEMORY_READBACK_EN is defined.
module wdmem_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
`ifdef WDATA_MEMORY_READBACK_EN
  ,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
`endif
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: the word lands in the array at the accepting edge
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

`ifdef WDATA_MEMORY_READBACK_EN
  // Registered read; a same-address write in the same cycle returns old data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end
`else
  // Without readback the array is write-only; keep one word referenced
  logic unused_mem_word;
  assign unused_mem_word = ^mem[0];
`endif

endmodule

// File: rtl/wdata_memory.sv
// Sequential result write-back memory. Accepts words over valid/ready and
// stores them at auto-incrementing addresses, tracking fill level, full and
// overflow. WRAP=1 keeps accepting when full, overwriting from address 0.
// Optional readback port enabled by the macro WDATA_MEMORY_READBACK_EN;
// without it rd_data reads 0 and rd_en/rd_addr are ignored.
module wdata_memory
  import wdmem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int WRAP   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              overflow,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [ADDR_W:0] COUNT_MAX = (ADDR_W+1)'(DEPTH);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic              overflow_reg, overflow_next;
  logic              accept;
  logic              mem_we;

  // ready comes only from registered state, never from wr_valid
  assign wr_ready = !((state_reg == FULL) && (WRAP == 0));
  assign accept   = wr_valid && wr_ready;
  // clear discards a coincident word, so memory is not written
  assign mem_we   = accept && !clear;

  assign wr_addr  = wr_addr_reg;
  assign count    = count_reg;
  assign full     = (state_reg == FULL);
  assign overflow = overflow_reg;

  // Pointer, count, fill state and overflow registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= EMPTY;
      wr_addr_reg  <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wr_addr_reg  <= wr_addr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  // Next-state: clear dominates; an accept advances the pointer modulo DEPTH
  always_comb begin
    state_next    = state_reg;
    wr_addr_next  = wr_addr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;
    if (clear) begin
      state_next    = EMPTY;
      wr_addr_next  = '0;
      count_next    = '0;
      overflow_next = 1'b0;
    end else if (accept) begin
      wr_addr_next = wr_addr_reg + ADDR_W'(1);
      if (count_reg != COUNT_MAX) begin
        count_next = count_reg + (ADDR_W+1)'(1);
      end
      case (state_reg)
        EMPTY, FILL: state_next = (count_next == COUNT_MAX) ? FULL : FILL;
        // Only reachable with WRAP=1: an accept here overwrites old data
        FULL:        overflow_next = 1'b1;
        default:     state_next = EMPTY;
      endcase
    end
  end

  wdmem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (wr_addr_reg),
    .wr_data (wr_data)
`ifdef WDATA_MEMORY_READBACK_EN
    ,
    .rst_n   (rst_n),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
`endif
  );

`ifndef WDATA_MEMORY_READBACK_EN
  logic unused_rd_inputs;
  assign unused_rd_inputs = ^{rd_en, rd_addr};
  assign rd_data = '0;
`endif

endmodule

// File: doc/wdata_memory.md
# wdata_memory

Sequential result write-back memory for the DSP datapath: accepts 32-bit results over a valid/ready handshake and stores them at auto-incrementing addresses starting from 0. It is the writer-side counterpart to the operand data memory reader. It sits at the tail of the processing pipeline, tracks fill level, and flags full or overflow. An optional registered readback port lets the host or testbench inspect stored results.

## Interface
Parameters:
- DATA_W, 32, data word width
- DEPTH, 1024, number of memory words (power of two)
- ADDR_W, $clog2(DEPTH), address width
- WRAP, 0, 0 = stop accepting writes when full; 1 = wrap to address 0, overwrite, and set overflow

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous flush: pointer, count and flags return to zero
- wr_valid  input  1  wr_data is valid
- wr_data  input  DATA_W  result word
- wr_ready  output  1  block can accept a word
- wr_addr  output  ADDR_W  address the next accepted word is written to
- count  output  ADDR_W+1  number of valid words stored, saturating at DEPTH
- full  output  1  count == DEPTH
- overflow  output  1  sticky; a write overwrote an unread-since-clear location (WRAP=1 only)
- rd_en  input  1  readback request
- rd_addr  input  ADDR_W  readback address
- rd_data  output  DATA_W  readback data

## Operation
- Accept: wr_valid && wr_ready at a rising edge. The word is written to mem[wr_addr], wr_addr increments, and count increments (saturating).
- State machine:
  - EMPTY: count 0.
  - FILL: 0 < count < DEPTH.
  - FULL: count == DEPTH.
  - EMPTY→FILL on the first accept.
  - FILL→FULL on the accept that makes count == DEPTH.
  - WRAP=0: FULL holds until clear or reset.
  - WRAP=1: in FULL, accepts continue. wr_addr wraps (DEPTH-1→0), count stays DEPTH, overflow sets.
- wr_ready = !(state==FULL && WRAP==0). It is driven from registered state only and has no combinational path from wr_valid.
- wr_addr increment is modulo DEPTH in both WRAP modes.
- clear (any state) returns the block to EMPTY: wr_addr=0, count=0, overflow=0. Memory contents are untouched.
- clear coincident with an accept: clear wins, the word is discarded and memory is not written.
- Readback: rd_en at an edge samples mem[rd_addr] into rd_data. rd_data holds its value when rd_en is low.
- Read and write to the same address in the same cycle: read-first, so rd_data returns the old contents.

## Timing
- Reset values: wr_addr=0, count=0, full=0, overflow=0, rd_data=0, state EMPTY, wr_ready=1. Memory array is not reset.
- Write latency: data is in memory at the accepting edge. It is visible to readback issued on the next cycle.
- full, count, wr_addr and wr_ready update on the same edge as the accept, so one word per cycle sustained.
- In FULL with WRAP=0, wr_ready is low starting from the cycle after the DEPTH-th accept.
- Readback latency: one cycle (rd_en at edge N → rd_data valid after edge N).
- Reset asserted mid-stream: all registers return to reset values immediately (asynchronous). No partial write occurs after deassertion.

## Configuration
- Macro: WDATA_MEMORY_READBACK_EN.
- Defined: readback port operational as described; the RAM has one write port and one read port.
- Undefined: read logic is not built; rd_data is tied to 0 and rd_en/rd_addr are ignored. The ports remain present so instantiations do not change.

## Structure
- Package wdmem_pkg: state enum (EMPTY, FILL, FULL), default DATA_W/DEPTH constants.
- Sub-module wdmem_ram: inferred simple dual-port RAM with read-first registered read. Its read port is instantiated only under WDATA_MEMORY_READBACK_EN.
- The top level holds the pointer, count, state machine and flags.

## Test plan
- Reset, then 4 writes 0x2FBC4A9D, 0xA57ED613, 0x3, 0x4 → count=4, wr_addr=4, full=0. Readback addresses 0..3 returns the same words one cycle after each rd_en.
- DEPTH=8, WRAP=0, 10 back-to-back writes → full=1 after the 8th, wr_ready low, words 9–10 dropped, mem[0]=first word.
- DEPTH=8, WRAP=1, 10 writes of 0..9 → overflow=1, count=8, wr_addr=2, mem[0]=8, mem[1]=9, mem[2]=2.
- clear asserted in the same cycle as an accepted write with data 0xDEAD → count=0, wr_addr=0, mem[wr_addr at that cycle] unchanged.
- Read and write to address 5 in the same cycle, with old 0x11 and new 0x22 → rd_data=0x11; readback next cycle → 0x22.
- rst_n pulsed low mid-stream after 3 writes → all outputs 0 and wr_ready=1 asynchronously; the next write lands at address 0.
